// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//
// Decodes the instruction sitting in ID and owns the ID/EX control register.
// It also resolves pipeline hazards: a load-use interlock, a multi-cycle
// stall while mulp/divp occupy EX, a branch flush, and an illegal-opcode trap.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_valid            ID-stage instruction valid
//   id_opcode/funct2    instruction opcode and funct fields
//   id_rs1/rs2/rd       register fields (register 0 never creates a hazard)
//   ex_branch_taken     EX resolved a taken branch/jump this cycle
//   ex_valid, ex_rd     ID/EX valid bit and registered destination register
//   ex_aluop, ex_*      registered control word presented to EX
//   stall               hold PC and IF/ID (combinational)
//   flush               invalidate IF/ID (combinational)
//   illegal             one-cycle pulse after an illegal opcode is decoded
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
   parameter int OPCODE_W = 3,
   parameter int FUNCT_W  = 2,
   parameter int REG_W    = 4,
   parameter int MUL_LAT  = 2,
   parameter int DIV_LAT  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [OPCODE_W-1:0] id_opcode,
   input  logic [FUNCT_W-1:0]  id_funct2,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                ex_branch_taken,
   output logic                ex_valid,
   output logic [REG_W-1:0]    ex_rd,
   output logic [1:0]          ex_aluop,
   output logic                ex_memtoreg,
   output logic                ex_branch,
   output logic                ex_byteenable,
   output logic                ex_memread,
   output logic                ex_memwrite,
   output logic                ex_regsrc,
   output logic                ex_alusrc,
   output logic                ex_regwrite,
   output logic                ex_cmp,
   output logic                ex_blt,
   output logic                ex_bge,
   output logic                ex_jmp,
   output logic                stall,
   output logic                flush,
   output logic                illegal
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   localparam logic [OPCODE_W-1:0] OP_ALU  = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_LOG  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_IMM  = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(5);

   localparam logic [FUNCT_W-1:0]  F_0     = FUNCT_W'(0);
   localparam logic [FUNCT_W-1:0]  F_1     = FUNCT_W'(1);
   localparam logic [FUNCT_W-1:0]  F_2     = FUNCT_W'(2);
   localparam logic [FUNCT_W-1:0]  F_3     = FUNCT_W'(3);

   typedef enum logic {RUN, MBUSY} state_t;

   typedef struct packed {
      logic [1:0] aluop;
      logic       memtoreg;
      logic       branch;
      logic       byteenable;
      logic       memread;
      logic       memwrite;
      logic       regsrc;
      logic       alusrc;
      logic       regwrite;
      logic       cmp;
      logic       blt;
      logic       bge;
      logic       jmp;
   } ctrl_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ex_valid_q, ex_valid_d;
   logic [REG_W-1:0]   ex_rd_q, ex_rd_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic               illegal_q, illegal_d;

   ctrl_t              dec_ctrl;
   logic               dec_illegal;
   logic               dec_rs2_used;
   logic               is_mul;
   logic               is_div;
   logic               load_use;
   logic               stall_c;
   logic               flush_c;

   // ---------------- ID decode ----------------
   always_comb begin
      dec_ctrl     = '0;
      dec_illegal  = 1'b0;
      dec_rs2_used = 1'b0;
      case (id_opcode)
         OP_ALU: begin
            dec_ctrl.aluop    = 2'b10;
            dec_ctrl.regwrite = 1'b1;
            dec_rs2_used      = 1'b1;
         end
         OP_LOG: begin
            dec_ctrl.aluop    = 2'b10;
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.cmp      = (id_funct2 == F_2);
            dec_rs2_used      = 1'b1;
         end
         OP_IMM: begin
            dec_ctrl.aluop    = 2'b00;
            dec_ctrl.alusrc   = 1'b1;
            dec_ctrl.regwrite = 1'b1;
         end
         OP_LW: begin
            dec_ctrl.memread    = 1'b1;
            dec_ctrl.memtoreg   = 1'b1;
            dec_ctrl.alusrc     = 1'b1;
            dec_ctrl.regwrite   = 1'b1;
            dec_ctrl.byteenable = (id_funct2 == F_0);
         end
         OP_SW: begin
            dec_ctrl.memwrite   = 1'b1;
            dec_ctrl.alusrc     = 1'b1;
            dec_ctrl.byteenable = (id_funct2 == F_0);
            dec_rs2_used        = 1'b1;
         end
         OP_BR: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.regsrc = 1'b1;
            dec_ctrl.alusrc = 1'b1;
            dec_ctrl.aluop  = 2'b01;
            dec_ctrl.blt    = (id_funct2 == F_0);
            dec_ctrl.bge    = (id_funct2 == F_1);
            dec_ctrl.jmp    = (id_funct2 == F_2);
            dec_rs2_used    = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign is_mul = (id_opcode == OP_ALU) && (id_funct2 == F_2);
   assign is_div = (id_opcode == OP_ALU) && (id_funct2 == F_3);

   // A load still in EX forwards nothing in time for a dependent ID op.
   assign load_use = ex_valid_q && ctrl_q.memread && (ex_rd_q != '0) && id_valid &&
                     ((ex_rd_q == id_rs1) || (dec_rs2_used && (ex_rd_q == id_rs2)));

   // ---------------- hazard control / next ID/EX word ----------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ex_valid_d = ex_valid_q;
      ex_rd_d    = ex_rd_q;
      ctrl_d     = ctrl_q;
      illegal_d  = 1'b0;
      stall_c    = 1'b0;
      flush_c    = 1'b0;
      case (state_q)
         RUN: begin
            // Every RUN cycle loads a bubble unless a real word is accepted.
            ex_valid_d = 1'b0;
            ctrl_d     = '0;
            if (ex_branch_taken) begin
               flush_c = 1'b1;
            end else if (load_use) begin
               stall_c = 1'b1;
            end else if (id_valid && dec_illegal) begin
               illegal_d = 1'b1;
            end else if (id_valid) begin
               ex_valid_d = 1'b1;
               ex_rd_d    = id_rd;
               ctrl_d     = dec_ctrl;
               if (is_mul && (MUL_LAT > 1)) begin
                  state_d = MBUSY;
                  cnt_d   = CNT_W'(MUL_LAT - 1);
               end else if (is_div && (DIV_LAT > 1)) begin
                  state_d = MBUSY;
                  cnt_d   = CNT_W'(DIV_LAT - 1);
               end
            end
         end
         MBUSY: begin
            // EX still busy: freeze the front end and hold ID/EX.
            stall_c = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // ---------------- ID/EX register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         ex_valid_q <= 1'b0;
         ex_rd_q    <= '0;
         ctrl_q     <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ex_valid_q <= ex_valid_d;
         ex_rd_q    <= ex_rd_d;
         ctrl_q     <= ctrl_d;
         illegal_q  <= illegal_d;
      end
   end

   // Gating with rst drops stall/flush the moment reset is asserted.
   assign stall         = stall_c & ~rst;
   assign flush         = flush_c & ~rst;
   assign illegal       = illegal_q;
   assign ex_valid      = ex_valid_q;
   assign ex_rd         = ex_rd_q;
   assign ex_aluop      = ctrl_q.aluop;
   assign ex_memtoreg   = ctrl_q.memtoreg;
   assign ex_branch     = ctrl_q.branch;
   assign ex_byteenable = ctrl_q.byteenable;
   assign ex_memread    = ctrl_q.memread;
   assign ex_memwrite   = ctrl_q.memwrite;
   assign ex_regsrc     = ctrl_q.regsrc;
   assign ex_alusrc     = ctrl_q.alusrc;
   assign ex_regwrite   = ctrl_q.regwrite;
   assign ex_cmp        = ctrl_q.cmp;
   assign ex_blt        = ctrl_q.blt;
   assign ex_bge        = ctrl_q.bge;
   assign ex_jmp        = ctrl_q.jmp;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
//
// Drives two instances of pipelined_control_unit with identical stimulus but
// different mul/div latencies (instance 0: MUL 1 / DIV 8, instance 1: MUL 3 /
// DIV 2) and checks both against a cycle-level reference model that tracks
// the ID/EX word and the number of stall cycles still owed to a busy EX op.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_opcode;
   logic [1:0] id_funct2;
   logic [3:0] id_rs1, id_rs2, id_rd;
   logic       ex_branch_taken;

   // obs[k] = {ex_valid, ex_rd[3:0], aluop[1:0], memtoreg, branch, byteenable,
   //           memread, memwrite, regsrc, alusrc, regwrite, cmp, blt, bge, jmp}
   wire [1:0][18:0] obs;
   wire [1:0]       stall_o;
   wire [1:0]       flush_o;
   wire [1:0]       ill_o;

   int checks = 0;
   int errors = 0;

   int lat_mul [2];
   int lat_div [2];

   // Reference model state per instance.
   logic        m_valid [2];
   logic [3:0]  m_rd    [2];
   logic [13:0] m_ctrl  [2];
   int          m_busy  [2];
   logic        m_ill   [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      wire       ev, mtr, br, be, mr, mw, rs, as, rw, cm, lt, ge, jp;
      wire [3:0] rd;
      wire [1:0] ao;
      pipelined_control_unit #(
         .OPCODE_W(3), .FUNCT_W(2), .REG_W(4),
         .MUL_LAT((k == 0) ? 1 : 3),
         .DIV_LAT((k == 0) ? 8 : 2)
      ) u_dut (
         .clk(clk), .rst(rst),
         .id_valid(id_valid), .id_opcode(id_opcode), .id_funct2(id_funct2),
         .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
         .ex_branch_taken(ex_branch_taken),
         .ex_valid(ev), .ex_rd(rd), .ex_aluop(ao),
         .ex_memtoreg(mtr), .ex_branch(br), .ex_byteenable(be),
         .ex_memread(mr), .ex_memwrite(mw), .ex_regsrc(rs),
         .ex_alusrc(as), .ex_regwrite(rw), .ex_cmp(cm),
         .ex_blt(lt), .ex_bge(ge), .ex_jmp(jp),
         .stall(stall_o[k]), .flush(flush_o[k]), .illegal(ill_o[k])
      );
      assign obs[k] = {ev, rd, ao, mtr, br, be, mr, mw, rs, as, rw, cm, lt, ge, jp};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Control word straight from the decode table:
   // {aluop[1:0], memtoreg, branch, byteenable, memread, memwrite,
   //  regsrc, alusrc, regwrite, cmp, blt, bge, jmp}
   function automatic logic [13:0] table_word(input logic [2:0] op, input logic [1:0] f);
      logic [1:0] aluop;
      logic mtr, br, be, mr, mw, rs, as, rw, cm, lt, ge, jp;
      {aluop, mtr, br, be, mr, mw, rs, as, rw, cm, lt, ge, jp} = '0;
      case (op)
         3'd0: begin aluop = 2'b10; rw = 1; end
         3'd1: begin aluop = 2'b10; rw = 1; cm = (f == 2); end
         3'd2: begin aluop = 2'b00; as = 1; rw = 1; end
         3'd3: begin mr = 1; mtr = 1; as = 1; rw = 1; be = (f == 0); end
         3'd4: begin mw = 1; as = 1; be = (f == 0); end
         3'd5: begin br = 1; rs = 1; as = 1; aluop = 2'b01;
                     lt = (f == 0); ge = (f == 1); jp = (f == 2); end
         default: ;
      endcase
      return {aluop, mtr, br, be, mr, mw, rs, as, rw, cm, lt, ge, jp};
   endfunction

   function automatic bit model_hazard(input int k);
      bit uses_rs2;
      uses_rs2 = (id_opcode == 0) || (id_opcode == 1) || (id_opcode == 4) || (id_opcode == 5);
      return m_valid[k] && m_ctrl[k][8] && (m_rd[k] != 0) && id_valid &&
             ((m_rd[k] == id_rs1) || (uses_rs2 && (m_rd[k] == id_rs2)));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 0; m_rd[k] = 0; m_ctrl[k] = 0; m_busy[k] = 0; m_ill[k] = 0;
      end
   endtask

   task automatic model_step(input int k);
      bit hz;
      hz = model_hazard(k);
      m_ill[k] = 0;
      if (m_busy[k] > 0) begin
         m_busy[k] = m_busy[k] - 1;
      end else if (ex_branch_taken || hz || !id_valid || id_opcode >= 6) begin
         m_valid[k] = 0;
         m_ctrl[k]  = 0;
         if (!ex_branch_taken && !hz && id_valid) m_ill[k] = 1;
      end else begin
         m_valid[k] = 1;
         m_rd[k]    = id_rd;
         m_ctrl[k]  = table_word(id_opcode, id_funct2);
         if (id_opcode == 0 && id_funct2 == 2) m_busy[k] = lat_mul[k] - 1;
         if (id_opcode == 0 && id_funct2 == 3) m_busy[k] = lat_div[k] - 1;
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] f,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                        input logic br);
      id_valid = v; id_opcode = op; id_funct2 = f;
      id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_branch_taken = br;
   endtask

   // One clock: check combinational stall/flush, clock, check registered outputs.
   task automatic tick();
      logic es, ef;
      #1;
      for (int k = 0; k < 2; k++) begin
         es = (m_busy[k] > 0) || (!ex_branch_taken && model_hazard(k));
         ef = (m_busy[k] == 0) && ex_branch_taken;
         chk($sformatf("stall[%0d]", k), 32'(stall_o[k]), 32'(es));
         chk($sformatf("flush[%0d]", k), 32'(flush_o[k]), 32'(ef));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ex_word[%0d]", k), 32'(obs[k]), 32'({m_valid[k], m_rd[k], m_ctrl[k]}));
         chk($sformatf("illegal[%0d]", k), 32'(ill_o[k]), 32'(m_ill[k]));
      end
   endtask

   initial begin
      int stalls;
      lat_mul[0] = 1; lat_div[0] = 8;
      lat_mul[1] = 3; lat_div[1] = 2;
      model_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_word", 32'(obs[k]), 32'd0);
         chk("reset_stall", 32'(stall_o[k]), 32'd0);
         chk("reset_flush", 32'(flush_o[k]), 32'd0);
         chk("reset_illegal", 32'(ill_o[k]), 32'd0);
      end
      rst = 1'b0;

      // addp r3
      drive(1, 0, 0, 1, 2, 3, 0); tick();
      chk("tp_addp_valid", 32'(obs[0][18]), 32'd1);
      chk("tp_addp_rd", 32'(obs[0][17:14]), 32'd3);
      chk("tp_addp_aluop", 32'(obs[0][13:12]), 32'd2);
      chk("tp_addp_regwrite", 32'(obs[0][4]), 32'd1);
      chk("tp_addp_stall", 32'(stall_o[0]), 32'd0);

      // lw r5 ; addp rs1=5 -> one stall with bubble
      drive(1, 3, 1, 0, 0, 5, 0); tick();
      drive(1, 0, 0, 5, 6, 7, 0);
      #1 chk("tp_lu_stall", 32'(stall_o[0]), 32'd1);
      tick();
      chk("tp_lu_bubble", 32'(obs[0][18]), 32'd0);
      tick();
      chk("tp_lu_issue", 32'(obs[0][18:14]), 32'h17);

      // lw r0 ; addp rs1=0 -> no stall
      drive(1, 3, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 4, 0);
      #1 chk("tp_lu_r0_stall", 32'(stall_o[0]), 32'd0);
      tick();

      // divp with DIV_LAT=8 -> 7 stall cycles
      drive(1, 0, 3, 1, 2, 8, 0); tick();
      drive(1, 0, 0, 1, 2, 9, 0);
      stalls = 0;
      for (int i = 0; i < 9; i++) begin
         #1 if (stall_o[0]) stalls++;
         tick();
      end
      chk("tp_div_stalls", 32'(stalls), 32'd7);
      chk("tp_div_next_rd", 32'(obs[0][17:14]), 32'd9);

      // mulp with MUL_LAT=1 -> no stall on instance 0
      drive(1, 0, 2, 1, 2, 10, 0); tick();
      drive(1, 0, 0, 1, 2, 11, 0);
      #1 chk("tp_mul1_stall", 32'(stall_o[0]), 32'd0);
      tick();

      // branch beats a load-use hazard
      drive(1, 3, 0, 0, 0, 5, 0); tick();
      drive(1, 0, 0, 5, 0, 12, 1);
      #1 chk("tp_br_flush", 32'(flush_o[0]), 32'd1);
      chk("tp_br_stall", 32'(stall_o[0]), 32'd0);
      tick();
      chk("tp_br_bubble", 32'(obs[0][18]), 32'd0);

      // illegal opcode 110 -> bubble and one-cycle pulse
      drive(1, 6, 0, 1, 2, 3, 0); tick();
      chk("tp_ill_pulse", 32'(ill_o[0]), 32'd1);
      chk("tp_ill_bubble", 32'(obs[0][18]), 32'd0);
      drive(1, 0, 0, 1, 2, 3, 0); tick();
      chk("tp_ill_clear", 32'(ill_o[0]), 32'd0);

      // branch funct2 11 -> branch only
      drive(1, 5, 3, 1, 2, 3, 0); tick();
      chk("tp_br11_branch", 32'(obs[0][10]), 32'd1);
      chk("tp_br11_cond", 32'(obs[0][2:0]), 32'd0);

      // reset in the 3rd MBUSY cycle
      drive(1, 0, 3, 1, 2, 4, 0); tick();
      drive(1, 0, 0, 1, 2, 5, 0); tick(); tick();
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_mid_word", 32'(obs[k]), 32'd0);
         chk("rst_mid_stall", 32'(stall_o[k]), 32'd0);
         chk("rst_mid_flush", 32'(flush_o[k]), 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1, 0, 0, 1, 2, 5, 0); tick();
      chk("rst_mid_reissue", 32'(obs[0][18:14]), 32'h15);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
